// File: rtl/instr_encoder.sv
// MIPS instruction encoder: descriptors in over valid/ready, addressed 32-bit words out of a small FIFO.
// Optional: define INSTR_ENC_DELAY_SLOT_EN to append a NOP delay slot after BEQ, BLTZ, J and JAL.
module instr_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       DEPTH     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        op_kind,
   input  logic [4:0]        op_rs,
   input  logic [4:0]        op_rt,
   input  logic [4:0]        op_rd,
   input  logic [31:0]       op_imm,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_addr,
   output logic [15:0]       words_emitted
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   localparam logic [3:0] K_NOP  = 4'd0,  K_ADDU  = 4'd1,  K_SUBU = 4'd2,  K_AND = 4'd3;
   localparam logic [3:0] K_OR   = 4'd4,  K_SLTU  = 4'd5,  K_LW   = 4'd6,  K_SW  = 4'd7;
   localparam logic [3:0] K_BEQ  = 4'd8,  K_ADDIU = 4'd9,  K_J    = 4'd10, K_ORI = 4'd11;
   localparam logic [3:0] K_LUI  = 4'd12, K_BLTZ  = 4'd13, K_JAL  = 4'd14, K_LI  = 4'd15;

   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;

   typedef enum logic {S_IDLE, S_SECOND} state_t;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   state_t              state_q, state_d;
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
   logic [31:0]         pend_q, pend_d;
   logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
   logic [15:0]         words_q, words_d;

   logic [31:0]         data_mem_q [DEPTH];
   logic [ADDR_W-1:0]   addr_mem_q [DEPTH];

   logic [31:0]         first_word;
   logic [31:0]         second_word;
   logic                need_second;
   logic [PTR_W:0]      fifo_count;
   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                push;
   logic                pop;
   logic [31:0]         push_data;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);

   // Descriptor decode: the word pushed on accept, plus an optional follow-up word.
   always_comb begin
      first_word  = '0;
      second_word = '0;
      need_second = 1'b0;
      case (op_kind)
         K_ADDU:  first_word = r_word(op_rs, op_rt, op_rd, 6'b100001);
         K_SUBU:  first_word = r_word(op_rs, op_rt, op_rd, 6'b100011);
         K_AND:   first_word = r_word(op_rs, op_rt, op_rd, 6'b100100);
         K_OR:    first_word = r_word(op_rs, op_rt, op_rd, 6'b100101);
         K_SLTU:  first_word = r_word(op_rs, op_rt, op_rd, 6'b101011);
         K_LW:    first_word = i_word(6'b100011, op_rs, op_rt, op_imm[15:0]);
         K_SW:    first_word = i_word(6'b101011, op_rs, op_rt, op_imm[15:0]);
         K_BEQ:   first_word = i_word(6'b000100, op_rs, op_rt, op_imm[15:0]);
         K_ADDIU: first_word = i_word(6'b001001, op_rs, op_rt, op_imm[15:0]);
         K_ORI:   first_word = i_word(OP_ORI, op_rs, op_rt, op_imm[15:0]);
         K_LUI:   first_word = i_word(OP_LUI, 5'd0, op_rt, op_imm[15:0]);
         K_BLTZ:  first_word = i_word(6'b000001, op_rs, 5'd0, op_imm[15:0]);
         K_J:     first_word = {6'b000010, op_imm[25:0]};
         K_JAL:   first_word = {6'b000011, op_imm[25:0]};
         K_LI: begin
            if (op_imm[31:16] == 16'h0000) begin
               first_word = i_word(OP_ORI, 5'd0, op_rt, op_imm[15:0]);
            end else begin
               first_word  = i_word(OP_LUI, 5'd0, op_rt, op_imm[31:16]);
               second_word = i_word(OP_ORI, op_rt, op_rt, op_imm[15:0]);
               need_second = (op_imm[15:0] != 16'h0000);
            end
         end
         default: first_word = '0;
      endcase
`ifdef INSTR_ENC_DELAY_SLOT_EN
      if (op_kind == K_BEQ || op_kind == K_BLTZ || op_kind == K_J || op_kind == K_JAL) begin
         need_second = 1'b1;
         second_word = '0;
      end
`endif
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (accept && need_second) state_d = S_SECOND;
            S_SECOND: if (!fifo_full) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      op_ready = (state_q == S_IDLE) && !fifo_full && reset;
   end

   assign accept    = op_valid && op_ready;
   assign push      = !restart && ((state_q == S_IDLE && accept) || (state_q == S_SECOND && !fifo_full));
   assign pop       = !restart && !fifo_empty && instr_ready;
   assign push_data = (state_q == S_SECOND) ? pend_q : first_word;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pend_d      = pend_q;
      next_addr_d = next_addr_q;
      words_d     = words_q;
      if (restart) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         pend_d      = '0;
         next_addr_d = BASE_ADDR;
         words_d     = '0;
      end else begin
         if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            next_addr_d = next_addr_q + ADDR_W'(4);
            words_d     = words_q + 16'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (state_q == S_IDLE && accept && need_second) begin
            pend_d = second_word;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pend_q      <= '0;
         next_addr_q <= BASE_ADDR;
         words_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pend_q      <= pend_d;
         next_addr_q <= next_addr_d;
         words_q     <= words_d;
      end
   end

   // Storage needs no reset: the empty flag masks stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
         addr_mem_q[wr_ptr_q[PTR_W-1:0]] <= next_addr_q;
      end
   end

   assign instr_valid   = !fifo_empty;
   assign instr         = fifo_empty ? '0 : data_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign instr_addr    = fifo_empty ? '0 : addr_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign words_emitted = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: queue-based reference model checked every cycle, plus pinned literals.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        restart = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [3:0]  op_kind = '0;
   logic [4:0]  op_rs = '0, op_rt = '0, op_rd = '0;
   logic [31:0] op_imm = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic [15:0] words_emitted;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .restart(restart),
      .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
      .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd), .op_imm(op_imm),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_addr(instr_addr), .words_emitted(words_emitted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] w; logic [31:0] a; } ent_t;
   ent_t        mq[$];
   ent_t        got[$];
   bit          m_pend = 0;
   logic [31:0] m_pw = '0;
   logic [31:0] m_addr = '0;
   logic [15:0] m_cnt = '0;

   function automatic void model_encode(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [31:0] imm,
                                        output int n, output logic [31:0] w0, output logic [31:0] w1);
      logic [5:0] funct [1:5];
      logic [5:0] iop;
      funct[1] = 6'h21; funct[2] = 6'h23; funct[3] = 6'h24; funct[4] = 6'h25; funct[5] = 6'h2B;
      n = 1; w1 = 32'h0; w0 = 32'h0; iop = 6'h0;
      if (k >= 1 && k <= 5) begin
         w0 = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct[k]);
      end else if (k == 10 || k == 14) begin
         w0 = ((k == 10 ? 32'd2 : 32'd3) << 26) | (imm & 32'h03FF_FFFF);
      end else if (k == 15) begin
         if (imm[31:16] == 0) w0 = (32'h0D << 26) | (32'(rt) << 16) | (imm & 32'hFFFF);
         else begin
            w0 = (32'h0F << 26) | (32'(rt) << 16) | (imm >> 16);
            if (imm[15:0] != 0) begin
               n = 2;
               w1 = (32'h0D << 26) | (32'(rt) << 21) | (32'(rt) << 16) | (imm & 32'hFFFF);
            end
         end
      end else if (k != 0) begin
         case (k)
            6: iop = 6'h23;  7: iop = 6'h2B;  8: iop = 6'h04;  9: iop = 6'h09;
            11: iop = 6'h0D; 12: iop = 6'h0F; 13: iop = 6'h01; default: iop = 6'h00;
         endcase
         w0 = (32'(iop) << 26) | (k == 12 ? 32'h0 : 32'(rs) << 21) |
              (k == 13 ? 32'h0 : 32'(rt) << 16) | (imm & 32'hFFFF);
      end
`ifdef INSTR_ENC_DELAY_SLOT_EN
      if (k == 8 || k == 13 || k == 10 || k == 14) begin n = 2; w1 = 32'h0; end
`endif
   endfunction

   task automatic model_push(input logic [31:0] w);
      ent_t e;
      e.w = w; e.a = m_addr;
      mq.push_back(e);
      m_addr = m_addr + 32'd4;
      m_cnt = m_cnt + 16'd1;
   endtask

   always @(posedge clk or negedge reset) begin
      int sz, n;
      logic [31:0] w0, w1;
      if (!reset || restart) begin
         mq.delete(); m_pend = 0; m_addr = 32'h0; m_cnt = '0;
      end else begin
         sz = mq.size();
         if (sz > 0 && instr_ready) void'(mq.pop_front());
         if (m_pend) begin
            if (sz < 4) begin model_push(m_pw); m_pend = 0; end
         end else if (sz < 4 && op_valid) begin
            model_encode(op_kind, op_rs, op_rt, op_rd, op_imm, n, w0, w1);
            model_push(w0);
            if (n == 2) begin m_pend = 1; m_pw = w1; end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      ent_t e;
      chk("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
      chk("op_ready", 64'(op_ready), 64'(reset && !m_pend && mq.size() < 4));
      chk("words_emitted", 64'(words_emitted), 64'(m_cnt));
      if (mq.size() != 0) begin
         chk("instr", 64'(instr), 64'(mq[0].w));
         chk("instr_addr", 64'(instr_addr), 64'(mq[0].a));
      end
      if (reset && !restart && instr_valid && instr_ready) begin
         e.w = instr; e.a = instr_addr;
         got.push_back(e);
         $display("pop instr=0x%08h addr=0x%08h", instr, instr_addr);
      end
   end

   // ---------------- drivers (all start/end at posedge+1) ----------------
   task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
      bit acc = 0;
      int n = 0;
      op_kind = k; op_rs = rs; op_rt = rt; op_rd = rd; op_imm = imm; op_valid = 1'b1;
      while (!acc && n < 100) begin
         @(negedge clk); acc = op_ready;
         @(posedge clk); #1; n++;
      end
      op_valid = 1'b0;
      if (!acc) chk("send_timeout", 64'(acc), 64'(1));
   endtask

   task automatic drain();
      int n = 0;
      while ((mq.size() != 0 || m_pend) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk("drain_timeout", 64'(n), 64'(0));
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      got.delete();
   endtask

   function automatic logic [63:0] got_word(input int i);
      return (i < got.size()) ? 64'(got[i].w) : 64'hDEAD_DEAD_DEAD;
   endfunction

   function automatic logic [63:0] got_addr(input int i);
      return (i < got.size()) ? 64'(got[i].a) : 64'hDEAD_DEAD_DEAD;
   endfunction

   initial begin
      repeat (2) @(posedge clk); #1;
      chk("rst_instr_valid", 64'(instr_valid), 64'(0));
      chk("rst_op_ready", 64'(op_ready), 64'(0));
      chk("rst_instr", 64'(instr), 64'(0));
      chk("rst_words", 64'(words_emitted), 64'(0));
      reset = 1'b1;
      @(posedge clk); #1;

      // ADDU after reset
      instr_ready = 1'b1;
      send(4'd1, 5'd1, 5'd2, 5'd3, 32'h0);
      chk("addu_words", 64'(words_emitted), 64'(1));
      drain();
      chk("addu_word", got_word(0), 64'h0022_1821);
      chk("addu_addr", got_addr(0), 64'h0);

      // LW then two-word LI
      do_restart();
      send(4'd6, 5'd9, 5'd8, 5'd0, 32'h4);
      send(4'd15, 5'd0, 5'd4, 5'd0, 32'h1234_5678);
      chk("li_second_ready_low", 64'(op_ready), 64'(0));
      @(posedge clk); #1;
      chk("li_ready_back", 64'(op_ready), 64'(1));
      drain();
      chk("lw_word", got_word(0), 64'h8D28_0004);
      chk("lui_word", got_word(1), 64'h3C04_1234);
      chk("lui_addr", got_addr(1), 64'h4);
      chk("ori_word", got_word(2), 64'h3484_5678);
      chk("ori_addr", got_addr(2), 64'h8);

      // single-word LI forms
      do_restart();
      send(4'd15, 5'd0, 5'd5, 5'd0, 32'h0000_0042);
      drain();
      chk("li_lo_word", got_word(0), 64'h3405_0042);
      chk("li_lo_count", 64'(got.size()), 64'(1));
      do_restart();
      send(4'd15, 5'd0, 5'd6, 5'd0, 32'hABCD_0000);
      drain();
      chk("li_hi_word", got_word(0), 64'h3C06_ABCD);
      chk("li_hi_count", 64'(got.size()), 64'(1));

      // fill FIFO, then J waits for space
      do_restart();
      instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
      chk("full_ready_low", 64'(op_ready), 64'(0));
      chk("full_valid", 64'(instr_valid), 64'(1));
      fork
         send(4'd10, 5'd0, 5'd0, 5'd0, 32'h100);
         begin repeat (3) @(posedge clk); #1; instr_ready = 1'b1; end
      join
      drain();
      chk("j_word", got_word(4), 64'h0800_0100);
      chk("j_addr", got_addr(4), 64'h10);

      // BEQ with/without delay slot
      do_restart();
      send(4'd8, 5'd1, 5'd2, 5'd0, 32'h3);
      drain();
      chk("beq_word", got_word(0), 64'h1022_0003);
`ifdef INSTR_ENC_DELAY_SLOT_EN
      chk("beq_count", 64'(got.size()), 64'(2));
      chk("beq_slot", got_word(1), 64'h0);
`else
      chk("beq_count", 64'(got.size()), 64'(1));
`endif

      // pinned I-type forms and a sweep over every kind
      do_restart();
      send(4'd9, 5'd3, 5'd7, 5'd0, 32'hFFFF_FFFC);
      send(4'd13, 5'd2, 5'd9, 5'd0, 32'h0000_FFFE);
      for (int k = 0; k < 16; k++)
         send(4'(k), 5'(k + 1), 5'(k + 2), 5'(k + 3), 32'h0001_0000 * k + 32'h8004);
      drain();
      chk("addiu_word", got_word(0), 64'h2467_FFFC);
      chk("bltz_word", got_word(1), 64'h0440_FFFE);

      // restart during SECOND aborts the ori word
      do_restart();
      instr_ready = 1'b0;
      send(4'd15, 5'd0, 5'd4, 5'd0, 32'h1234_5678);
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      got.delete();
      chk("rs_valid", 64'(instr_valid), 64'(0));
      chk("rs_words", 64'(words_emitted), 64'(0));
      chk("rs_ready", 64'(op_ready), 64'(1));
      instr_ready = 1'b1;
      send(4'd1, 5'd1, 5'd2, 5'd3, 32'h0);
      drain();
      chk("rs_next_addr", got_addr(0), 64'h0);
      chk("rs_count", 64'(got.size()), 64'(1));

      // async reset mid-stream
      instr_ready = 1'b0;
      send(4'd1, 5'd4, 5'd5, 5'd6, 32'h0);
      send(4'd6, 5'd1, 5'd2, 5'd0, 32'h10);
      #2 reset = 1'b0;
      #1;
      chk("ar_valid", 64'(instr_valid), 64'(0));
      chk("ar_ready", 64'(op_ready), 64'(0));
      chk("ar_instr", 64'(instr), 64'(0));
      chk("ar_addr", 64'(instr_addr), 64'(0));
      chk("ar_words", 64'(words_emitted), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
